// File: rtl/dcache_dm_pkg.sv
// ============================================================================
// Module      : dcache_dm_pkg
// Description : Shared buses, state encodings and byte-lane helper for dcache_dm.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dcache_dm_pkg;

  typedef logic [31:0] AddrBus;
  typedef logic [31:0] DataBus;
  typedef logic [2:0]  LenBus;
  typedef logic [3:0]  NickBus;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_WRITE  = 2'd2,
    ST_BYPASS = 2'd3
  } state_e;

  localparam logic [1:0] IO_REGION = 2'b11;

  localparam LenBus LEN_BYTE = 3'd1;
  localparam LenBus LEN_HALF = 3'd2;
  localparam LenBus LEN_WORD = 3'd4;

  // Pull len bytes starting at byte offset off out of a word, zero-extended.
  function automatic DataBus extract_bytes(DataBus w, logic [1:0] off, LenBus len);
    DataBus s;
    s = w >> {off, 3'b000};
    case (len)
      LEN_BYTE: return {24'd0, s[7:0]};
      LEN_HALF: return {16'd0, s[15:0]};
      default:  return s;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_array.sv
// ============================================================================
// Module      : dcache_array
// Description : Direct-mapped line storage: valid/tag/data arrays with
//               combinational read, full-line fill and byte-lane merge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_array
  import dcache_dm_pkg::*;
#(
  parameter int INDEX_W = 6,
  parameter int TAG_W   = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_idx_i,
  output logic               rd_valid_o,
  output logic [TAG_W-1:0]   rd_tag_o,
  output logic [31:0]        rd_data_o,
  input  logic               fill_en_i,
  input  logic [INDEX_W-1:0] fill_idx_i,
  input  logic [TAG_W-1:0]   fill_tag_i,
  input  logic [31:0]        fill_data_i,
  input  logic               merge_en_i,
  input  logic [1:0]         merge_off_i,
  input  logic [2:0]         merge_len_i,
  input  logic [31:0]        merge_data_i
);

  localparam int LINES = 1 << INDEX_W;

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  logic [3:0]  w_be;
  logic [31:0] w_shifted;

  // Merge writes to the line addressed by the read port (the accepted request).
  always_comb begin
    w_shifted = merge_data_i << {merge_off_i, 3'b000};
    w_be      = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      if ((4'(b) >= {2'b00, merge_off_i}) &&
          (4'(b) <  ({2'b00, merge_off_i} + {1'b0, merge_len_i})))
        w_be[b] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      valid_q <= '0;
    else if (fill_en_i)
      valid_q[fill_idx_i] <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      tag_q[fill_idx_i]  <= fill_tag_i;
      data_q[fill_idx_i] <= fill_data_i;
    end else if (merge_en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b])
          data_q[rd_idx_i][8*b +: 8] <= w_shifted[8*b +: 8];
      end
    end
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[rd_idx_i];

endmodule

`default_nettype wire

// File: rtl/dcache_dm.sv
// ============================================================================
// Module      : dcache_dm
// Description : Direct-mapped write-through data cache with IO bypass.
//               Optional hit/miss counters under DCACHE_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dcache_dm
  import dcache_dm_pkg::*;
#(
  parameter int         INDEX_W = 6,
  parameter int         NICK_W  = 4,
  parameter logic [1:0] IO_HI   = IO_REGION
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              iSLB_en,
  input  logic              iSLB_ls,
  input  logic [31:0]       iSLB_pc,
  input  logic [31:0]       iSLB_dt,
  input  logic [2:0]        iSLB_len,
  input  logic [NICK_W-1:0] iSLB_nick,
  output logic              oSLB_busy,
  output logic              oSLB_done,
  output logic [31:0]       oSLB_dt,
  output logic [NICK_W-1:0] oSLB_nick,
  output logic              oMC_en,
  output logic              oMC_ls,
  output logic [31:0]       oMC_pc,
  output logic [31:0]       oMC_dt,
  output logic [2:0]        oMC_len,
  input  logic              iMC_done,
  input  logic [31:0]       iMC_dt
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0]       oHit_cnt,
  output logic [31:0]       oMiss_cnt
`endif
);

  localparam int TAG_W = 32 - INDEX_W - 2;

  state_e             state_q;
  logic [NICK_W-1:0]  nick_q;
  LenBus              len_q;
  logic [1:0]         off_q;
  logic [INDEX_W-1:0] fill_idx_q;
  logic [TAG_W-1:0]   fill_tag_q;
  logic               mc_en_q, mc_ls_q, done_q;
  AddrBus             mc_pc_q;
  DataBus             mc_dt_q, sdt_q;
  LenBus              mc_len_q;
  logic [NICK_W-1:0]  snick_q;

  logic [INDEX_W-1:0] w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [3:0]         w_span;
  logic               w_cached, w_hit, w_accept;
  logic               w_rd_valid;
  logic [TAG_W-1:0]   w_rd_tag;
  DataBus             w_rd_data;

  assign w_idx     = iSLB_pc[INDEX_W+1:2];
  assign w_tag     = iSLB_pc[31:INDEX_W+2];
  assign w_span    = {2'b00, iSLB_pc[1:0]} + {1'b0, iSLB_len};
  assign w_cached  = (iSLB_pc[17:16] != IO_HI) && (w_span <= 4'd4);
  assign w_hit     = w_cached && w_rd_valid && (w_rd_tag == w_tag);
  assign oSLB_busy = (state_q != ST_IDLE) || !rdy;
  assign w_accept  = iSLB_en && !oSLB_busy && !rst;

  dcache_array #(
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk          (clk),
    .rst          (rst),
    .rd_idx_i     (w_idx),
    .rd_valid_o   (w_rd_valid),
    .rd_tag_o     (w_rd_tag),
    .rd_data_o    (w_rd_data),
    .fill_en_i    (rdy && !rst && iMC_done && (state_q == ST_FILL)),
    .fill_idx_i   (fill_idx_q),
    .fill_tag_i   (fill_tag_q),
    .fill_data_i  (iMC_dt),
    .merge_en_i   (w_accept && iSLB_ls && w_hit),
    .merge_off_i  (iSLB_pc[1:0]),
    .merge_len_i  (iSLB_len),
    .merge_data_i (iSLB_dt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      nick_q     <= '0;
      len_q      <= '0;
      off_q      <= '0;
      fill_idx_q <= '0;
      fill_tag_q <= '0;
      mc_en_q    <= 1'b0;
      mc_ls_q    <= 1'b0;
      mc_pc_q    <= '0;
      mc_dt_q    <= '0;
      mc_len_q   <= '0;
      done_q     <= 1'b0;
      sdt_q      <= '0;
      snick_q    <= '0;
    end else if (rdy) begin
      mc_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (iSLB_en) begin
            nick_q     <= iSLB_nick;
            len_q      <= iSLB_len;
            off_q      <= iSLB_pc[1:0];
            fill_idx_q <= w_idx;
            fill_tag_q <= w_tag;
            if (!iSLB_ls && w_hit) begin
              done_q  <= 1'b1;
              sdt_q   <= extract_bytes(w_rd_data, iSLB_pc[1:0], iSLB_len);
              snick_q <= iSLB_nick;
            end else begin
              mc_en_q <= 1'b1;
              mc_ls_q <= iSLB_ls;
              mc_dt_q <= iSLB_ls ? iSLB_dt : '0;
              if (!iSLB_ls && w_cached) begin
                mc_pc_q  <= {iSLB_pc[31:2], 2'b00};
                mc_len_q <= LEN_WORD;
                state_q  <= ST_FILL;
              end else begin
                mc_pc_q  <= iSLB_pc;
                mc_len_q <= iSLB_len;
                state_q  <= iSLB_ls ? ST_WRITE : ST_BYPASS;
              end
            end
          end
        end
        default: begin
          if (iMC_done) begin
            done_q  <= 1'b1;
            snick_q <= nick_q;
            state_q <= ST_IDLE;
            case (state_q)
              ST_FILL:   sdt_q <= extract_bytes(iMC_dt, off_q, len_q);
              ST_BYPASS: sdt_q <= extract_bytes(iMC_dt, 2'b00, len_q);
              default:   sdt_q <= '0;
            endcase
          end
        end
      endcase
    end
  end

  assign oMC_en    = mc_en_q;
  assign oMC_ls    = mc_ls_q;
  assign oMC_pc    = mc_pc_q;
  assign oMC_dt    = mc_dt_q;
  assign oMC_len   = mc_len_q;
  assign oSLB_done = done_q;
  assign oSLB_dt   = sdt_q;
  assign oSLB_nick = snick_q;

`ifdef DCACHE_PERF_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (w_accept && !iSLB_ls && w_cached) begin
      if (w_hit)
        hit_cnt_q <= hit_cnt_q + 32'd1;
      else
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign oHit_cnt  = hit_cnt_q;
  assign oMiss_cnt = miss_cnt_q;
`endif

endmodule

`default_nettype wire
